tucanos_process_scheduler: RTL and testbench

Round-robin process scheduler sitting between the quantum watchdog and the instruction fetch/PC logic.
- Consumes watchdog events (quantum expired, I/O wait, halt).
- Saves the running process's PC into an internal context table and selects the next READY process.
- Issues a one-cycle resume strobe with that process's saved PC.
- Tracks per-process status. Accepts process-load and I/O-completion notifications from the operating system.

---
 rtl/tucanos_process_scheduler.sv | 232 +++++++++++++++++++++++
 tb/tb_tucanos_process_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tucanos_process_scheduler.sv
// Round-robin process scheduler: saves the running PC on a watchdog event and dispatches the next READY slot.
// Latency: resume_valid in cycle 2+k after event acceptance (k = examined slots); events during busy are dropped.
// Optional TUCANOS_SCHED_STATS_EN adds saturating switch_count and dropped_count outputs.
module tucanos_process_scheduler #(
    parameter int NUM_PROCESSES = 4,
    parameter int INDEX_WIDTH   = 2,
    parameter int PC_WIDTH      = 12
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       event_valid,
    input  logic [1:0]                 event_code,
    input  logic [PC_WIDTH-1:0]        current_pc,
    input  logic                       start_valid,
    input  logic [INDEX_WIDTH-1:0]     start_index,
    input  logic [PC_WIDTH-1:0]        start_pc,
    input  logic                       io_done_valid,
    input  logic [INDEX_WIDTH-1:0]     io_done_index,
    output logic                       busy,
    output logic                       resume_valid,
    output logic [PC_WIDTH-1:0]        resume_pc,
    output logic [INDEX_WIDTH-1:0]     current_index,
    output logic                       idle,
    output logic [2*NUM_PROCESSES-1:0] process_status
`ifdef TUCANOS_SCHED_STATS_EN
    ,
    output logic [15:0]                switch_count,
    output logic [7:0]                 dropped_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SAVE     = 2'd1,
        S_SELECT   = 2'd2,
        S_DISPATCH = 2'd3
    } state_e;

    localparam logic [1:0] ST_EMPTY   = 2'b00;
    localparam logic [1:0] ST_READY   = 2'b01;
    localparam logic [1:0] ST_RUNNING = 2'b10;
    localparam logic [1:0] ST_WAITING = 2'b11;

    localparam logic [INDEX_WIDTH:0] LAST_MISS = (INDEX_WIDTH+1)'(NUM_PROCESSES - 1);

    state_e                                 state_q, state_d;
    logic [NUM_PROCESSES-1:0][1:0]          status_q, status_d;
    logic [NUM_PROCESSES-1:0][PC_WIDTH-1:0] pc_table_q, pc_table_d;
    logic [INDEX_WIDTH-1:0]                 cur_idx_q, cur_idx_d;
    logic [INDEX_WIDTH-1:0]                 scan_q, scan_d;
    logic [INDEX_WIDTH:0]                   miss_q, miss_d;
    logic                                   idle_q, idle_d;
    logic                                   resume_valid_q, resume_valid_d;
    logic [PC_WIDTH-1:0]                    resume_pc_q, resume_pc_d;
    logic [PC_WIDTH-1:0]                    save_pc_q, save_pc_d;
    logic [1:0]                             save_code_q, save_code_d;

    logic                   event_accept;
    logic                   fsm_wr;
    logic [INDEX_WIDTH-1:0] fsm_idx;
    logic                   start_apply;
    logic                   io_apply;
    logic                   any_ready;

    assign event_accept = event_valid && (state_q == S_IDLE) && !idle_q && (event_code != 2'b11);

    // SAVE and DISPATCH own their slot's status for the cycle; OS requests to it lose.
    always_comb begin
        fsm_wr  = 1'b0;
        fsm_idx = cur_idx_q;
        if (state_q == S_SAVE) begin
            fsm_wr  = 1'b1;
            fsm_idx = cur_idx_q;
        end else if (state_q == S_DISPATCH) begin
            fsm_wr  = 1'b1;
            fsm_idx = scan_q;
        end
    end

    assign start_apply = start_valid && (status_q[start_index] == ST_EMPTY)
                         && !(fsm_wr && (fsm_idx == start_index));
    assign io_apply    = io_done_valid && (status_q[io_done_index] == ST_WAITING)
                         && !(fsm_wr && (fsm_idx == io_done_index));

    always_comb begin
        state_d        = state_q;
        status_d       = status_q;
        pc_table_d     = pc_table_q;
        cur_idx_d      = cur_idx_q;
        scan_d         = scan_q;
        miss_d         = miss_q;
        idle_d         = idle_q;
        resume_valid_d = 1'b0;
        resume_pc_d    = resume_pc_q;
        save_pc_d      = save_pc_q;
        save_code_d    = save_code_q;
        any_ready      = 1'b0;

        if (start_apply) begin
            status_d[start_index]   = ST_READY;
            pc_table_d[start_index] = start_pc;
        end
        if (io_apply) begin
            status_d[io_done_index] = ST_READY;
        end

        for (int i = 0; i < NUM_PROCESSES; i++) begin
            if (status_d[i] == ST_READY) begin
                any_ready = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (event_accept) begin
                    save_pc_d   = current_pc;
                    save_code_d = event_code;
                    state_d     = S_SAVE;
                end else if (idle_q && any_ready) begin
                    scan_d  = cur_idx_q + 1'b1;
                    miss_d  = '0;
                    state_d = S_SELECT;
                end
            end
            S_SAVE: begin
                pc_table_d[cur_idx_q] = save_pc_q;
                case (save_code_q)
                    2'b00:   status_d[cur_idx_q] = ST_READY;
                    2'b01:   status_d[cur_idx_q] = ST_WAITING;
                    default: status_d[cur_idx_q] = ST_EMPTY;
                endcase
                idle_d  = 1'b1;
                scan_d  = cur_idx_q + 1'b1;
                miss_d  = '0;
                state_d = S_SELECT;
            end
            S_SELECT: begin
                // scan_q is held on a hit so DISPATCH knows which slot won.
                if (status_q[scan_q] == ST_READY) begin
                    resume_valid_d = 1'b1;
                    resume_pc_d    = pc_table_q[scan_q];
                    state_d        = S_DISPATCH;
                end else begin
                    scan_d = scan_q + 1'b1;
                    if (miss_q == LAST_MISS) begin
                        idle_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        miss_d = miss_q + 1'b1;
                    end
                end
            end
            S_DISPATCH: begin
                status_d[scan_q] = ST_RUNNING;
                cur_idx_d        = scan_q;
                idle_d           = 1'b0;
                state_d          = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            status_q       <= '0;
            pc_table_q     <= '0;
            cur_idx_q      <= '0;
            scan_q         <= '0;
            miss_q         <= '0;
            idle_q         <= 1'b1;
            resume_valid_q <= 1'b0;
            resume_pc_q    <= '0;
            save_pc_q      <= '0;
            save_code_q    <= '0;
        end else begin
            state_q        <= state_d;
            status_q       <= status_d;
            pc_table_q     <= pc_table_d;
            cur_idx_q      <= cur_idx_d;
            scan_q         <= scan_d;
            miss_q         <= miss_d;
            idle_q         <= idle_d;
            resume_valid_q <= resume_valid_d;
            resume_pc_q    <= resume_pc_d;
            save_pc_q      <= save_pc_d;
            save_code_q    <= save_code_d;
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign resume_valid   = resume_valid_q;
    assign resume_pc      = resume_pc_q;
    assign current_index  = cur_idx_q;
    assign idle           = idle_q;
    assign process_status = status_q;

`ifdef TUCANOS_SCHED_STATS_EN
    logic [15:0] switch_q, switch_d;
    logic [7:0]  dropped_q, dropped_d;
    logic [1:0]  drop_inc;
    logic [8:0]  drop_sum;

    // Up to three requests can be dropped in one cycle.
    assign drop_inc = 2'(event_valid && !event_accept)
                    + 2'(start_valid && !start_apply)
                    + 2'(io_done_valid && !io_apply);
    assign drop_sum = {1'b0, dropped_q} + {7'b0, drop_inc};

    always_comb begin
        switch_d  = switch_q;
        dropped_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        if (resume_valid_q && (switch_q != 16'hFFFF)) begin
            switch_d = switch_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            switch_q  <= '0;
            dropped_q <= '0;
        end else begin
            switch_q  <= switch_d;
            dropped_q <= dropped_d;
        end
    end

    assign switch_count  = switch_q;
    assign dropped_count = dropped_q;
`endif

endmodule

// File: tb/tb_tucanos_process_scheduler.sv
// Directed bench for tucanos_process_scheduler: walks load, quantum, I/O wait, halt, drop and reset scenarios.
module tb_tucanos_process_scheduler;

    logic        clock;
    logic        reset_n;
    logic        event_valid;
    logic [1:0]  event_code;
    logic [11:0] current_pc;
    logic        start_valid;
    logic [1:0]  start_index;
    logic [11:0] start_pc;
    logic        io_done_valid;
    logic [1:0]  io_done_index;
    logic        busy;
    logic        resume_valid;
    logic [11:0] resume_pc;
    logic [1:0]  current_index;
    logic        idle;
    logic [7:0]  process_status;
`ifdef TUCANOS_SCHED_STATS_EN
    logic [15:0] switch_count;
    logic [7:0]  dropped_count;
`endif

    int checks = 0;
    int errors = 0;
    int n;
    logic seen;

    tucanos_process_scheduler #(
        .NUM_PROCESSES(4),
        .INDEX_WIDTH  (2),
        .PC_WIDTH     (12)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .event_valid   (event_valid),
        .event_code    (event_code),
        .current_pc    (current_pc),
        .start_valid   (start_valid),
        .start_index   (start_index),
        .start_pc      (start_pc),
        .io_done_valid (io_done_valid),
        .io_done_index (io_done_index),
        .busy          (busy),
        .resume_valid  (resume_valid),
        .resume_pc     (resume_pc),
        .current_index (current_index),
        .idle          (idle),
        .process_status(process_status)
`ifdef TUCANOS_SCHED_STATS_EN
        ,
        .switch_count  (switch_count),
        .dropped_count (dropped_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ticks until resume_valid is seen or the bound expires; n = ticks taken.
    task automatic wait_resume(input int bound, output int cnt);
        cnt = 0;
        while (resume_valid !== 1'b1 && cnt < bound) begin
            tick();
            cnt++;
        end
    endtask

    task automatic do_event(input logic [1:0] code, input logic [11:0] pc);
        event_valid = 1'b1;
        event_code  = code;
        current_pc  = pc;
        tick();
        event_valid = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] idx, input logic [11:0] pc);
        start_valid = 1'b1;
        start_index = idx;
        start_pc    = pc;
        tick();
        start_valid = 1'b0;
    endtask

    initial begin
        reset_n       = 1'b0;
        event_valid   = 1'b0;
        event_code    = 2'b00;
        current_pc    = '0;
        start_valid   = 1'b0;
        start_index   = '0;
        start_pc      = '0;
        io_done_valid = 1'b0;
        io_done_index = '0;
        repeat (3) tick();

        check("rst_status", process_status, 32'h00);
        check("rst_idle", idle, 1);
        check("rst_busy", busy, 0);
        check("rst_rv", resume_valid, 0);
        check("rst_pc", resume_pc, 0);
        check("rst_cur", current_index, 0);
`ifdef TUCANOS_SCHED_STATS_EN
        check("rst_sw", switch_count, 0);
        check("rst_drop", dropped_count, 0);
`endif
        reset_n = 1'b1;
        tick();

        // Load slots 1 and 2; slot 1 dispatched from IDLE.
        start_valid = 1'b1;
        start_index = 2'd1;
        start_pc    = 12'h010;
        tick();
        start_index = 2'd2;
        start_pc    = 12'h020;
        tick();
        start_valid = 1'b0;
        wait_resume(20, n);
        check("load_rv", resume_valid, 1);
        check("load_pc", resume_pc, 12'h010);
        tick();
        check("load_rv_pulse", resume_valid, 0);
        check("load_cur", current_index, 1);
        check("load_status", process_status, 8'h18);
        check("load_idle", idle, 0);

        // Quantum expiry on slot 1: slot 2 is first examined, k=1.
        do_event(2'b00, 12'h015);
        check("q_busy", busy, 1);
        check("q_rv_save", resume_valid, 0);
        wait_resume(20, n);
        check("q_lat", n, 2);
        check("q_rv", resume_valid, 1);
        check("q_pc", resume_pc, 12'h020);
        tick();
        check("q_cur", current_index, 2);
        check("q_status", process_status, 8'h24);

        // I/O wait on slot 2: slots 3,0 miss, slot 1 hits (k=3).
        do_event(2'b01, 12'h024);
        wait_resume(20, n);
        check("io_lat", n, 4);
        check("io_pc", resume_pc, 12'h015);
        tick();
        check("io_cur", current_index, 1);
        check("io_status", process_status, 8'h38);
        io_done_valid = 1'b1;
        io_done_index = 2'd2;
        tick();
        io_done_valid = 1'b0;
        check("iodone_status", process_status, 8'h18);

        // Slot 2 resumes at the PC saved by the I/O wait.
        do_event(2'b00, 12'h01A);
        wait_resume(20, n);
        check("q2_lat", n, 2);
        check("q2_pc", resume_pc, 12'h024);
        tick();
        check("q2_status", process_status, 8'h24);

        // Halt slot 2 -> slot 1 (k=3).
        do_event(2'b10, 12'h02F);
        wait_resume(20, n);
        check("h1_lat", n, 4);
        check("h1_pc", resume_pc, 12'h01A);
        tick();
        check("h1_status", process_status, 8'h08);
        do_start(2'd3, 12'h030);
        check("s3_status", process_status, 8'h48);
        check("s3_busy", busy, 0);

        // Halt slot 1 -> slot 3 (k=2).
        do_event(2'b10, 12'h01F);
        wait_resume(20, n);
        check("h2_lat", n, 3);
        check("h2_pc", resume_pc, 12'h030);
        tick();
        check("h2_cur", current_index, 3);
        check("h2_status", process_status, 8'h80);

        // Halt the only process: four misses then IDLE.
        do_event(2'b10, 12'h033);
        seen = 1'b0;
        repeat (4) begin
            if (resume_valid === 1'b1) seen = 1'b1;
            tick();
        end
        check("h3_busy4", busy, 1);
        if (resume_valid === 1'b1) seen = 1'b1;
        tick();
        check("h3_busy", busy, 0);
        check("h3_idle", idle, 1);
        check("h3_status", process_status, 8'h00);
        check("h3_cur", current_index, 3);
        check("h3_no_rv", seen, 0);

        // Slot 0 loaded while idle; scan wraps from slot 3 to 0.
        do_start(2'd0, 12'h040);
        wait_resume(20, n);
        check("s0_rv", resume_valid, 1);
        check("s0_pc", resume_pc, 12'h040);
        tick();
        check("s0_cur", current_index, 0);
        check("s0_status", process_status, 8'h02);
        do_start(2'd1, 12'h050);
        check("s1_status", process_status, 8'h06);

        // While busy: event, start to READY slot, io_done to READY slot all dropped.
        do_event(2'b00, 12'h044);
        event_valid   = 1'b1;
        event_code    = 2'b00;
        current_pc    = 12'h0EE;
        start_valid   = 1'b1;
        start_index   = 2'd1;
        start_pc      = 12'h0FF;
        io_done_valid = 1'b1;
        io_done_index = 2'd1;
        tick();
        event_valid   = 1'b0;
        start_valid   = 1'b0;
        io_done_valid = 1'b0;
        wait_resume(20, n);
        check("drop_lat", n, 1);
        check("drop_pc", resume_pc, 12'h050);
        tick();
        check("drop_cur", current_index, 1);
        check("drop_status", process_status, 8'h09);
        check("drop_busy", busy, 0);
`ifdef TUCANOS_SCHED_STATS_EN
        check("drop_count", dropped_count, 3);
        check("switch_count", switch_count, 8);
`endif

        // Reserved code is ignored.
        do_event(2'b11, 12'h066);
        check("rsv_busy", busy, 0);
        check("rsv_status", process_status, 8'h09);

        // Reset asserted during SELECT aborts the dispatch.
        do_event(2'b00, 12'h055);
        tick();
        check("mid_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_status", process_status, 8'h00);
        check("mid_rst_idle", idle, 1);
        seen = 1'b0;
        repeat (3) begin
            tick();
            if (resume_valid === 1'b1) seen = 1'b1;
        end
        reset_n = 1'b1;
        repeat (6) begin
            tick();
            if (resume_valid === 1'b1) seen = 1'b1;
        end
        check("mid_no_rv", seen, 0);
        check("mid_idle", idle, 1);
        check("mid_busy_after", busy, 0);
        check("mid_cur", current_index, 0);
        check("mid_status", process_status, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
